// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
//   Multi-cycle RISC-V style control FSM (Moore). Walks each instruction through
//   FETCH / FETCH_WAIT / DECODE and then an opcode-specific execute sequence,
//   issuing one set of datapath strobes per state.
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous, active-low reset
//   i6_0           opcode of the instruction register
//   i14_12         funct3 of the instruction register
//   i30            funct7[5] of the instruction register
//   AluZero        ALU zero flag    (used only in BRANCH)
//   AluIgual       ALU equal flag   (used only in BRANCH)
//   PCwrite .. loadRegAluOut   1-bit datapath strobes
//   SelMuxA        ALU A select     (0=PC, 1=RegA)
//   SelMuxB        ALU B select     (0=RegB, 1=4, 2=SignExit, 3=ShiftLeftExit)
//   SelMuxMem      write-back sel   (0=AluOut, 1=LoadResultExit, 3=SignExit)
//   SelMuxPC       PC source        (0=AluExit, 1=AluOut)
//   AluOperation   ALU op           (1=add, 2=sub, 5=and, 7=compare)
//   EPCWrite       EPC load strobe
//   SelMuxExc      exception-vector PC select
//
// Configuration
//   CONTROL_UNIT_EXCEPTION_EN  defined: an unknown opcode saves EPC and jumps to
//                              the exception vector. Undefined: an unknown
//                              opcode halts like HALT; EPCWrite/SelMuxExc stay 0.
// -----------------------------------------------------------------------------
module control_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] i6_0,
  input  logic [2:0] i14_12,
  input  logic       i30,
  input  logic       AluZero,
  input  logic       AluIgual,
  output logic       PCwrite,
  output logic       PCWriteCond,
  output logic       MemRead,
  output logic       MemData_Write,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       loadRegA,
  output logic       loadRegB,
  output logic       loadRegMemData,
  output logic       loadRegAluOut,
  output logic [2:0] SelMuxA,
  output logic [2:0] SelMuxB,
  output logic [2:0] SelMuxMem,
  output logic       SelMuxPC,
  output logic [2:0] AluOperation,
  output logic       EPCWrite,
  output logic       SelMuxExc
);

  typedef enum logic [3:0] {
    FETCH, FETCH_WAIT, DECODE, EXEC_R, EXEC_I, WB_ALU, MEM_ADDR, MEM_READ,
    MEM_WAIT, WB_LD, MEM_WRITE, BRANCH, WB_LUI, HALT, INVALID, EXC_JUMP
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       mem_read;
    logic       mem_data_write;
    logic       ir_write;
    logic       reg_write;
    logic       load_a;
    logic       load_b;
    logic       load_md;
    logic       load_aluout;
    logic [2:0] sel_a;
    logic [2:0] sel_b;
    logic [2:0] sel_mem;
    logic       sel_pc;
    logic [2:0] alu_op;
    logic       epc_write;
    logic       sel_exc;
  } ctrl_t;

  state_t r_state;
  state_t w_next;
  ctrl_t  r_ctrl;
  // Low while in reset and for nothing after: the first edge after release
  // enters FETCH (rather than leaving it) so that FETCH gets a full cycle.
  logic   r_run;
  logic   w_branch_taken;

  // Strobes belonging to a state; any field not set is 0.
  function automatic ctrl_t decode(input state_t s, input logic [2:0] f3,
                                   input logic f7);
    ctrl_t o;
    o = '0;
    case (s)
      FETCH: o.mem_read = 1'b1;
      FETCH_WAIT: begin
        o.ir_write = 1'b1;
        o.sel_b    = 3'd1;
        o.alu_op   = 3'd1;
        o.pc_write = 1'b1;
      end
      DECODE: begin
        o.load_a      = 1'b1;
        o.load_b      = 1'b1;
        o.sel_b       = 3'd3;
        o.alu_op      = 3'd1;
        o.load_aluout = 1'b1;
      end
      EXEC_R: begin
        o.sel_a       = 3'd1;
        o.load_aluout = 1'b1;
        if (f7 && f3 == 3'b000) o.alu_op = 3'd2;
        else if (f3 == 3'b111)  o.alu_op = 3'd5;
        else                    o.alu_op = 3'd1;
      end
      EXEC_I, MEM_ADDR: begin
        o.sel_a       = 3'd1;
        o.sel_b       = 3'd2;
        o.alu_op      = 3'd1;
        o.load_aluout = 1'b1;
      end
      WB_ALU:    o.reg_write = 1'b1;
      MEM_READ:  o.mem_read  = 1'b1;
      MEM_WAIT:  o.load_md   = 1'b1;
      WB_LD: begin
        o.reg_write = 1'b1;
        o.sel_mem   = 3'd1;
      end
      MEM_WRITE: o.mem_data_write = 1'b1;
      BRANCH: begin
        o.sel_a         = 3'd1;
        o.alu_op        = 3'd7;
        o.pc_write_cond = 1'b1;
        o.sel_pc        = 1'b1;
      end
      WB_LUI: begin
        o.reg_write = 1'b1;
        o.sel_mem   = 3'd3;
      end
`ifdef CONTROL_UNIT_EXCEPTION_EN
      INVALID: begin
        o.sel_b     = 3'd1;
        o.alu_op    = 3'd2;
        o.epc_write = 1'b1;
      end
      EXC_JUMP: begin
        o.pc_write = 1'b1;
        o.sel_exc  = 1'b1;
      end
`endif
      default: o = '0;
    endcase
    return o;
  endfunction

  always_comb begin
    w_next = r_state;
    if (!r_run) begin
      w_next = FETCH;
    end else begin
      case (r_state)
        FETCH:      w_next = FETCH_WAIT;
        FETCH_WAIT: w_next = DECODE;
        DECODE: begin
          case (i6_0)
            7'b0110011:             w_next = EXEC_R;
            7'b0010011:             w_next = EXEC_I;
            7'b0000011, 7'b0100011: w_next = MEM_ADDR;
            7'b1100011:             w_next = BRANCH;
            7'b0110111:             w_next = WB_LUI;
            7'b1110011:             w_next = HALT;
            default:                w_next = INVALID;
          endcase
        end
        EXEC_R, EXEC_I: w_next = WB_ALU;
        MEM_ADDR:       w_next = i6_0[5] ? MEM_WRITE : MEM_READ;
        MEM_READ:       w_next = MEM_WAIT;
        MEM_WAIT:       w_next = WB_LD;
        HALT:           w_next = HALT;
`ifdef CONTROL_UNIT_EXCEPTION_EN
        INVALID:        w_next = EXC_JUMP;
`else
        INVALID:        w_next = INVALID;
`endif
        default:        w_next = FETCH;  // WB_*, MEM_WRITE, BRANCH, EXC_JUMP
      endcase
    end
  end

  // Outputs are registered as the decode of the state being entered, so each
  // register always holds the Moore decode of r_state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= FETCH;
      r_run   <= 1'b0;
      r_ctrl  <= '0;
    end else begin
      r_state <= w_next;
      r_run   <= 1'b1;
      r_ctrl  <= decode(w_next, i14_12, i30);
    end
  end

  // The ALU flags are produced during BRANCH itself, so the conditional PC
  // write cannot be registered ahead of time.
  assign w_branch_taken = (r_state == BRANCH) &&
                          ((i14_12 == 3'b000 && AluIgual) ||
                           (i14_12 == 3'b001 && !AluZero));

  assign PCwrite        = r_ctrl.pc_write | w_branch_taken;
  assign PCWriteCond    = r_ctrl.pc_write_cond;
  assign MemRead        = r_ctrl.mem_read;
  assign MemData_Write  = r_ctrl.mem_data_write;
  assign IRWrite        = r_ctrl.ir_write;
  assign RegWrite       = r_ctrl.reg_write;
  assign loadRegA       = r_ctrl.load_a;
  assign loadRegB       = r_ctrl.load_b;
  assign loadRegMemData = r_ctrl.load_md;
  assign loadRegAluOut  = r_ctrl.load_aluout;
  assign SelMuxA        = r_ctrl.sel_a;
  assign SelMuxB        = r_ctrl.sel_b;
  assign SelMuxMem      = r_ctrl.sel_mem;
  assign SelMuxPC       = r_ctrl.sel_pc;
  assign AluOperation   = r_ctrl.alu_op;
  assign EPCWrite       = r_ctrl.epc_write;
  assign SelMuxExc      = r_ctrl.sel_exc;

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL: clk  input  1  system clock; all state changes on the rising edge.
REQ-002 SHALL: rst  input  1  reset, asynchronous, active-low.
REQ-003 SHALL: i6_0  input  7  opcode of the instruction register.
REQ-004 SHALL: i14_12  input  3  funct3 of the instruction register.
REQ-005 SHALL: i30  input  1  funct7[5] of the instruction register.
REQ-006 SHALL: AluZero, AluIgual  input  1 each  ALU flags, sampled only in state BRANCH.
REQ-007 SHALL: PCwrite, PCWriteCond, MemRead, MemData_Write, IRWrite, RegWrite, loadRegA, loadRegB, loadRegMemData, loadRegAluOut  output  1 each  datapath strobes.
REQ-008 SHALL: SelMuxA  output  3  ALU operand A select: 0=PC, 1=RegA.
REQ-009 SHALL: SelMuxB  output  3  ALU operand B select: 0=RegB, 1=constant 4, 2=SignExit, 3=ShiftLeftExit.
REQ-010 SHALL: SelMuxMem  output  3  write-back select: 0=AluOut, 1=LoadResultExit, 3=SignExit.
REQ-011 SHALL: SelMuxPC  output  1  PC source: 0=AluExit, 1=AluOut.
REQ-012 SHALL: AluOperation  output  3  ALU op: 1=add, 2=sub, 5=and, 7=compare.
REQ-013 SHALL: EPCWrite, SelMuxExc  output  1 each  EPC load and exception-vector PC select.

Function
REQ-014 SHALL: Moore FSM; every output is decoded from the current state only; any output not listed for a state is 0.
REQ-015 SHALL: FETCH: MemRead=1; next state FETCH_WAIT.
REQ-016 SHALL: FETCH_WAIT: IRWrite=1, SelMuxA=0, SelMuxB=1, AluOperation=1, SelMuxPC=0, PCwrite=1 (PC<=PC+4); next state DECODE.
REQ-017 SHALL: DECODE: loadRegA=1, loadRegB=1, SelMuxA=0, SelMuxB=3, AluOperation=1, loadRegAluOut=1 (branch target); dispatch on i6_0.
REQ-018 SHALL: dispatch 0110011 -> EXEC_R; 0010011 -> EXEC_I; 0000011 or 0100011 -> MEM_ADDR; 1100011 -> BRANCH; 0110111 -> WB_LUI; 1110011 -> HALT; any other opcode -> INVALID.
REQ-019 SHALL: EXEC_R: SelMuxA=1, SelMuxB=0, loadRegAluOut=1; AluOperation=2 if i30=1 and i14_12=000, 5 if i14_12=111, else 1; next state WB_ALU.
REQ-020 SHALL: EXEC_I: SelMuxA=1, SelMuxB=2, AluOperation=1, loadRegAluOut=1; next state WB_ALU.
REQ-021 SHALL: WB_ALU: RegWrite=1, SelMuxMem=0; next state FETCH.
REQ-022 SHALL: MEM_ADDR: SelMuxA=1, SelMuxB=2, AluOperation=1, loadRegAluOut=1; next state MEM_READ for a load, MEM_WRITE for a store.
REQ-023 SHALL: MEM_READ: MemRead=1 -> MEM_WAIT: loadRegMemData=1 -> WB_LD: RegWrite=1, SelMuxMem=1 -> FETCH.
REQ-024 SHALL: MEM_WRITE: MemData_Write=1 for exactly one cycle; next state FETCH.
REQ-025 SHALL: BRANCH: SelMuxA=1, SelMuxB=0, AluOperation=7, PCWriteCond=1, SelMuxPC=1; PCwrite=1 when (i14_12=000 and AluIgual=1) or (i14_12=001 and AluZero=0); next state FETCH.
REQ-026 SHALL: WB_LUI: RegWrite=1, SelMuxMem=3; next state FETCH.
REQ-027 SHALL: HALT: all outputs 0; state held until reset.
REQ-028 SHALL: instruction latency in cycles, from FETCH entry to the next FETCH: R-type and addi 5; ld 7; sd 5; branch 4; lui 4.

Reset
REQ-029 SHALL: rst=0 forces state FETCH immediately and asynchronously and drives all outputs to 0, overriding the Moore decode of FETCH while rst=0.
REQ-030 SHALL: reset asserted mid-instruction aborts the instruction; no further strobe is issued; the first FETCH cycle begins at the first rising edge after rst=1.

Configuration
REQ-031 SHALL: macro CONTROL_UNIT_EXCEPTION_EN compiled in: INVALID: SelMuxA=0, SelMuxB=1, AluOperation=2, EPCWrite=1 (EPC<=PC-4) -> EXC_JUMP: PCwrite=1, SelMuxExc=1 -> FETCH.
REQ-032 SHALL: macro absent: INVALID behaves as HALT; EPCWrite and SelMuxExc are tied to 0; the port list is unchanged.

Verification
REQ-033 SHALL: add x3,x1,x2 (i6_0=0110011, i14_12=000, i30=0) after reset -> EXEC_R asserts AluOperation=1; RegWrite=1 in cycle 5; MemRead=1 in cycle 6.
REQ-034 SHALL: ld (i6_0=0000011) -> MemRead=1 in cycles 1 and 5, loadRegMemData=1 in cycle 6, RegWrite=1 with SelMuxMem=1 in cycle 7.
REQ-035 SHALL: beq (i14_12=000) run with AluIgual=1 and then with AluIgual=0 -> cycle 4 has PCWriteCond=1 in both runs; PCwrite=1 with SelMuxPC=1 only when AluIgual=1.
REQ-036 SHALL: i6_0=1111111 -> with the macro: EPCWrite=1 in cycle 4, PCwrite=1 with SelMuxExc=1 in cycle 5, FETCH in cycle 6; without the macro: all outputs 0 indefinitely.
REQ-037 SHALL: rst=0 pulsed during MEM_READ of an ld -> all outputs 0 at once; loadRegMemData and RegWrite never asserted; after release MemRead=1 on the first cycle (FETCH).
REQ-038 SHALL: sd (i6_0=0100011) -> MemData_Write=1 for exactly one cycle (cycle 5); RegWrite=0 throughout.
